led_indicator_ctrl: RTL and testbench
=====================================

# led_indicator_ctrl

Multi-channel LED pattern generator that drives N_CH indicator LEDs, each independently set to off, dimmed-solid, blink or breathing mode. It generalises the fan controller's single status-LED driver. Upstream status logic (battery, charging, fan gear) maps its conditions onto per-channel mode and brightness codes, and this block generates the waveforms. All pattern timing is derived from clk through parameterised dividers, with no clock multiplier or derived clocks.

## Interface
- N_CH, 4: number of LED channels (1..16)
- PWM_BITS, 4: brightness resolution; PWM period = 2^PWM_BITS clk cycles; MAXL = 2^PWM_BITS-1
- BLINK_HALF, 25: blink half-period in clk cycles (>=1); 25 gives 2 Hz at 100 Hz clk
- STEP_DIV, 2: PWM periods per breathing step (>=1)
- ACTIVE_LOW, 0: 1 inverts every led output bit
- clk  in  1  system clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- en  in  1  global enable; 0 forces all LEDs inactive (fan neutral gear)
- mode  in  2*N_CH  per-channel mode, ch i at [2i+1:2i]: 00 OFF, 01 ON, 10 BLINK, 11 BREATHE
- brightness  in  N_CH*PWM_BITS  per-channel ON-mode duty, ch i at [PWM_BITS*i +: PWM_BITS]
- led  out  N_CH  LED drive, registered

## Operation
- pwm_cnt (PWM_BITS, shared): free-running, increments every cycle, wraps MAXL->0.
- pwm_wrap: asserted in the cycle where pwm_cnt==MAXL.
- step_cnt (shared): counts pwm_wrap events 0..STEP_DIV-1. step_tick = pwm_wrap && step_cnt==STEP_DIV-1; step_cnt wraps to 0 on step_tick.
- blink_cnt (shared): counts 0..BLINK_HALF-1. blink_ph toggles on the terminal count, then blink_cnt returns to 0.
- Per-channel breathing state: level (PWM_BITS) and dir (0 = up), updated only on step_tick.
  - Up: if level==MAXL, set dir=1 and hold level (one-step dwell); else level+1.
  - Down: if level==0, set dir=0 and hold level; else level-1.
- Entry into BREATHE: prev_mode[i] != 11 while mode[i]==11 loads level=0, dir=0. This load takes priority over a coincident step_tick. Envelope stays frozen while mode[i] != 11.
- Raw channel output, before the register:
  - OFF: 0
  - ON: brightness==MAXL gives 1 (solid, no PWM gap); else pwm_cnt < brightness. Brightness 0 gives constant 0.
  - BLINK: blink_ph
  - BREATHE: level==MAXL gives 1; else pwm_cnt < level
- Gating and polarity: en==0 forces raw output to 0, then ACTIVE_LOW XOR is applied, then the result is registered into led.
- en does not stop the shared counters or the envelopes.
- mode and brightness are sampled every cycle and may change on any cycle; no handshake.

## Timing
- Reset values: led = {N_CH{ACTIVE_LOW}} (all inactive); pwm_cnt, step_cnt, blink_cnt, blink_ph = 0; all level = 0, dir = 0; prev_mode = 00.
- Latency: 1 cycle from any mode, brightness, en or counter change to led.
- First blink-high led cycle after reset release: cycle BLINK_HALF+1 (blink_ph goes 1 after BLINK_HALF edges, plus the register stage).
- Breathing triangle period: 2*(MAXL+1) steps = 2*(MAXL+1)*STEP_DIV*2^PWM_BITS cycles (1024 at defaults).
- Reset asserted mid-pattern returns all state to the reset values immediately, independent of clk.

## Structure
- Package led_indicator_pkg holds the mode codes (LED_OFF, LED_ON, LED_BLINK, LED_BREATHE) as a 2-bit enum; the upstream status mapper uses the same package.
- Sub-module led_breath_env is instantiated once per channel. Inputs: step_tick, restart. Outputs: level.
- Shared counters live in the top level.

## Test plan
- Reset: hold rst_n=0 with mode ch0=ON and brightness=15 -> led=0000. Release -> led[0]=1 from the 2nd post-release edge onward and stays constant.
- ON dimming: ch1 ON, brightness=4 -> led[1] high exactly 4 of every 16 cycles (pwm_cnt 0..3). Brightness=0 -> constant 0.
- BLINK: ch2 BLINK from reset -> led[2] low for the first 25 post-reset cycles, then toggles every 25 cycles (50-cycle period).
- BREATHE: ch3 switched to 11 mid-run -> level restarts at 0 and steps every 32 cycles up to 15. Two steps hold at 15, then descends. Full period 1024 cycles; level==15 gives solid high.
- Global enable: en=0 mid-breathe -> all led 0 next cycle. en=1 after 100 cycles -> envelope resumes at its advanced position, not restarted.
- Polarity/mixed: ACTIVE_LOW=1, channels OFF/ON(15)/BLINK/BREATHE simultaneously -> led[0]=1, led[1]=0, led[3:2] = inverted waveforms of the ACTIVE_LOW=0 run. During reset all bits are 1.

Source files
------------

// File: rtl/led_indicator_pkg.sv
// Shared definitions for the indicator LED driver and the upstream status mapper.
package led_indicator_pkg;

  // Per-channel mode code, two bits per channel on the mode bus.
  typedef enum logic [1:0] {
    LED_OFF     = 2'b00,
    LED_ON      = 2'b01,
    LED_BLINK   = 2'b10,
    LED_BREATHE = 2'b11
  } led_mode_e;

  // PWM compare used by both the dimmed-solid and breathing outputs.
  // A full-scale duty gives a solid 1 instead of losing one cycle per period.
  // Callers zero-extend their PWM_BITS-wide values to 16 bits.
  function automatic logic pwm_on(input logic [15:0] cnt,
                                  input logic [15:0] duty,
                                  input logic [15:0] maxl);
    return (duty == maxl) || (cnt < duty);
  endfunction

endpackage

// File: rtl/led_breath_env.sv
// Breathing envelope for one channel: a triangle level that ramps 0..MAXL..0,
// dwelling for one step at each end, and advances only when step_tick is high.
module led_breath_env #(
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_tick,
  input  logic                restart,
  output logic [PWM_BITS-1:0] level
);

  localparam logic [PWM_BITS-1:0] MAXL = '1;

  logic [PWM_BITS-1:0] level_q, level_d;
  logic                dir_q, dir_d;  // 0 = rising, 1 = falling

  // Next envelope state; a restart wins over a coincident step.
  always_comb begin
    level_d = level_q;
    dir_d   = dir_q;
    if (restart) begin
      level_d = '0;
      dir_d   = 1'b0;
    end else if (step_tick) begin
      if (!dir_q) begin
        if (level_q == MAXL) dir_d   = 1'b1;
        else                 level_d = level_q + 1'b1;
      end else begin
        if (level_q == '0)   dir_d   = 1'b0;
        else                 level_d = level_q - 1'b1;
      end
    end
  end

  // Envelope registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      dir_q   <= dir_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/led_indicator_ctrl.sv
// Multi-channel indicator LED pattern generator: off, dimmed-solid, blink and
// breathing per channel, all timed from clk by shared free-running dividers.
module led_indicator_ctrl
  import led_indicator_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned BLINK_HALF = 25,
  parameter int unsigned STEP_DIV   = 2,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [2*N_CH-1:0]        mode,
  input  logic [N_CH*PWM_BITS-1:0] brightness,
  output logic [N_CH-1:0]          led
);

  localparam logic [PWM_BITS-1:0] MAXL = '1;
  localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned STEP_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_ph_q, blink_ph_d;
  logic                pwm_wrap, step_tick;
  logic [N_CH-1:0]     raw;
  logic [N_CH-1:0]     led_q, led_d;

  // Shared timebase: PWM counter, breathing step prescaler and blink divider.
  always_comb begin
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    pwm_wrap    = (pwm_cnt_q == MAXL);
    step_tick   = pwm_wrap && (step_cnt_q == STEP_LAST);
    step_cnt_d  = step_cnt_q;
    if (pwm_wrap) step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_ph_d  = blink_ph_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  // Shared timebase registers; they keep running while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q   <= '0;
      step_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      step_cnt_q  <= step_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      led_mode_e           mode_ch;
      led_mode_e           prev_mode_q, prev_mode_d;
      logic [PWM_BITS-1:0] bright_ch;
      logic [PWM_BITS-1:0] level;
      logic                restart;
      logic                env_tick;
      logic                raw_bit;

      assign mode_ch   = led_mode_e'(mode[2*gi +: 2]);
      assign bright_ch = brightness[PWM_BITS*gi +: PWM_BITS];
      // Envelope restarts on the first cycle of BREATHE and is frozen otherwise.
      assign restart   = (mode_ch == LED_BREATHE) && (prev_mode_q != LED_BREATHE);
      assign env_tick  = step_tick && (mode_ch == LED_BREATHE);

      led_breath_env #(
        .PWM_BITS (PWM_BITS)
      ) u_env (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_tick (env_tick),
        .restart   (restart),
        .level     (level)
      );

      // Remember the previous mode to detect entry into BREATHE.
      always_comb prev_mode_d = mode_ch;

      // Previous-mode register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_mode_q <= LED_OFF;
        else        prev_mode_q <= prev_mode_d;
      end

      // Raw waveform for this channel before gating and polarity.
      always_comb begin
        raw_bit = 1'b0;
        case (mode_ch)
          LED_OFF:     raw_bit = 1'b0;
          LED_ON:      raw_bit = pwm_on(16'(pwm_cnt_q), 16'(bright_ch), 16'(MAXL));
          LED_BLINK:   raw_bit = blink_ph_q;
          LED_BREATHE: raw_bit = pwm_on(16'(pwm_cnt_q), 16'(level), 16'(MAXL));
          default:     raw_bit = 1'b0;
        endcase
      end

      assign raw[gi] = raw_bit;
    end
  endgenerate

  // Global enable gating then output polarity.
  always_comb led_d = (en ? raw : '0) ^ {N_CH{ACTIVE_LOW}};

  // Output register; reset drives every LED to its inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= {N_CH{ACTIVE_LOW}};
    else        led_q <= led_d;
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_indicator_ctrl.sv
// Scoreboard bench for led_indicator_ctrl: the stimulus process predicts each
// registered led value and queues it, a monitor pops and compares every cycle.
// A second instance with ACTIVE_LOW=1 shares the inputs and must be the inverse.
module tb_led_indicator_ctrl;

  localparam int N  = 4;
  localparam int BH = 25;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [7:0]  mode = 8'h00;
  logic [15:0] brightness = 16'h0000;
  logic [3:0]  led_a, led_b;

  led_indicator_ctrl #(
    .N_CH(4), .PWM_BITS(4), .BLINK_HALF(BH), .STEP_DIV(SD), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .brightness(brightness), .led(led_a)
  );

  led_indicator_ctrl #(
    .N_CH(4), .PWM_BITS(4), .BLINK_HALF(BH), .STEP_DIV(SD), .ACTIVE_LOW(1'b1)
  ) dut_inv (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .brightness(brightness), .led(led_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  // Reference model state.
  int m_pc, m_sc, m_bc;
  bit m_bph;
  int m_lvl[N];
  bit m_dir[N];
  int m_pm[N];

  task automatic model_reset();
    m_pc = 0; m_sc = 0; m_bc = 0; m_bph = 0;
    for (int c = 0; c < N; c++) begin
      m_lvl[c] = 0; m_dir[c] = 0; m_pm[c] = 0;
    end
  endtask

  // Predict the led value the next edge will register, advance the model, and
  // wait out that edge (returns on the following falling edge).
  task automatic cyc();
    logic [3:0] raw;
    bit wrap, tick;
    int md, br;
    raw = 4'h0;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back(4'h0);
    end else begin
      for (int c = 0; c < N; c++) begin
        md = int'(mode[2*c +: 2]);
        br = int'(brightness[4*c +: 4]);
        case (md)
          0: raw[c] = 1'b0;
          1: raw[c] = (br == 15) || (m_pc < br);
          2: raw[c] = m_bph;
          default: raw[c] = (m_lvl[c] == 15) || (m_pc < m_lvl[c]);
        endcase
      end
      exp_q.push_back(en ? raw : 4'h0);
      wrap = (m_pc == 15);
      tick = wrap && (m_sc == SD - 1);
      for (int c = 0; c < N; c++) begin
        md = int'(mode[2*c +: 2]);
        if (md == 3) begin
          if (m_pm[c] != 3) begin
            m_lvl[c] = 0; m_dir[c] = 0;
          end else if (tick) begin
            if (!m_dir[c]) begin
              if (m_lvl[c] == 15) m_dir[c] = 1; else m_lvl[c]++;
            end else begin
              if (m_lvl[c] == 0) m_dir[c] = 0; else m_lvl[c]--;
            end
          end
        end
        m_pm[c] = md;
      end
      if (wrap) m_sc = tick ? 0 : m_sc + 1;
      if (m_bc == BH - 1) begin m_bc = 0; m_bph = !m_bph; end
      else m_bc++;
      m_pc = (m_pc + 1) % 16;
    end
    @(negedge clk);
  endtask

  // Directed check against a hand-computed value; one line per check.
  task automatic hcheck(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end else begin
      $display("check %s ok: %0d", name, act);
    end
  endtask

  // Monitor: led is registered every cycle, so each edge is one transaction.
  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (led_a !== e || led_b !== ~e) begin
          errors++;
          $display("FAIL model_cmp t=%0t: led=%b led_inv=%b required %b/%b",
                   $time, led_a, led_b, e, ~e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int on_low, dim_cnt, run, maxrun, hi_cnt;
    model_reset();
    // Reset with ch0 ON full, ch1 ON dim 4, ch2 BLINK, ch3 OFF.
    mode       = {2'b00, 2'b10, 2'b01, 2'b01};
    brightness = {4'd0, 4'd0, 4'd4, 4'd15};
    en         = 1'b1;
    rst_n      = 1'b0;
    repeat (4) cyc();
    hcheck("reset_led", int'(led_a), 0);
    hcheck("reset_led_inv", int'(led_b), 15);

    rst_n = 1'b1;
    on_low = 0; dim_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      if (k >= 2 && led_a[0] !== 1'b1) on_low++;
      if (k >= 17 && k <= 32 && led_a[1] === 1'b1) dim_cnt++;
      if (k == 25) hcheck("blink_low_e25", int'(led_a[2]), 0);
      if (k == 26) hcheck("blink_high_e26", int'(led_a[2]), 1);
      if (k == 50) hcheck("blink_high_e50", int'(led_a[2]), 1);
      if (k == 51) hcheck("blink_low_e51", int'(led_a[2]), 0);
    end
    hcheck("on_full_steady", on_low, 0);
    hcheck("on_dim4_count", dim_cnt, 4);

    // Brightness 0 gives a constant 0.
    brightness[7:4] = 4'd0;
    cyc();
    dim_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (led_a[1] === 1'b1) dim_cnt++;
    end
    hcheck("on_dim0_count", dim_cnt, 0);

    // Breathing on ch3 entered mid-run.
    mode[7:6] = 2'b11;
    run = 0; maxrun = 0; hi_cnt = 0;
    for (int k = 1; k <= 1200; k++) begin
      cyc();
      if (led_a[3] === 1'b1) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (k >= 101 && k <= 1124 && led_a[3] === 1'b1) hi_cnt++;
    end
    hcheck("breathe_solid_run", maxrun, 78);
    hcheck("breathe_period_highs", hi_cnt, 484);

    // Global enable off mid-breathe, then resume.
    en = 1'b0;
    cyc();
    hcheck("en_off_led", int'(led_a), 0);
    hcheck("en_off_led_inv", int'(led_b), 15);
    repeat (99) cyc();
    en = 1'b1;
    repeat (300) cyc();

    // Mixed modes: OFF / ON full / BLINK / BREATHE.
    mode = {2'b11, 2'b10, 2'b01, 2'b00};
    brightness[7:4] = 4'd15;
    repeat (2) cyc();
    hcheck("mix_inv_ch0", int'(led_b[0]), 1);
    hcheck("mix_inv_ch1", int'(led_b[1]), 0);
    // Leave and re-enter BREATHE to exercise the restart.
    mode[7:6] = 2'b01;
    repeat (40) cyc();
    mode[7:6] = 2'b11;
    repeat (150) cyc();

    // Asynchronous reset mid-pattern, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    hcheck("async_rst_led", int'(led_a), 0);
    hcheck("async_rst_led_inv", int'(led_b), 15);
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (60) cyc();

    repeat (2) @(negedge clk);
    hcheck("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
